// File: rtl/sprite_fetch_arbiter_pkg.sv
// Shared types and constants for the sprite ROM fetch arbiter.
// The ROM select encoding is {shark, right}, so it maps straight onto
// the two per-requester sprite attribute bits.
package sprite_pkg;

    typedef enum logic [1:0] {
        FISH_L  = 2'b00,
        FISH_R  = 2'b01,
        SHARK_L = 2'b10,
        SHARK_R = 2'b11
    } rom_sel_t;

    localparam int          FISH_DEP  = 1024;
    localparam int          SHARK_DEP = 49152;
    localparam int          ADDR_W    = 19;
    localparam int          PIX_W     = 4;
    localparam int          ID_W      = 3;
    localparam logic [3:0]  TRANSP    = 4'h0;

    // One entry of the fixed-latency response pipeline
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        rom_sel_t        sel;
        logic            oob;
    } fetch_stage_t;

    // Build the ROM select from the requester's sprite attributes
    function automatic rom_sel_t make_sel(input logic shark, input logic right);
        return rom_sel_t'({shark, right});
    endfunction

endpackage

// File: rtl/sprite_fetch_arbiter_rr.sv
// Combinational round-robin picker: searches from rr_ptr upward, wrapping
// to index 0. The pointer register itself lives in the parent.
// With PLAYER_PRIORITY_EN defined, requester 0 always wins when asserted.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    // Two passes: first the indices at or above the pointer, then the wrapped-around low indices
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (ID_W'(i) >= rr_ptr)) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
`ifdef PLAYER_PRIORITY_EN
        if (req[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
        gnt = found ? (N_REQ'(1) << winner) : '0;
    end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Sprite ROM fetch arbiter: shares the four sprite ROMs (fish L/R, shark L/R)
// between N_REQ draw-pipeline requesters. One grant per cycle, round-robin,
// fixed two-cycle response latency, responses tagged with requester id.
// Optional build macro: PLAYER_PRIORITY_EN gives requester 0 absolute priority
// and leaves the round-robin pointer untouched on its grants.
module sprite_fetch_arbiter #(
    parameter int         N_REQ     = 4,
    parameter int         FISH_DEP  = sprite_pkg::FISH_DEP,
    parameter int         SHARK_DEP = sprite_pkg::SHARK_DEP,
    parameter logic [3:0] TRANSP    = sprite_pkg::TRANSP
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       req_shark,
    input  logic [N_REQ-1:0]       req_right,
    input  logic [N_REQ*19-1:0]    req_off,
    output logic [N_REQ-1:0]       gnt,
    output logic [18:0]            rom_addr,
    input  logic [3:0]             fish_l_d,
    input  logic [3:0]             fish_r_d,
    input  logic [3:0]             shark_l_d,
    input  logic [3:0]             shark_r_d,
    output logic                   rsp_valid,
    output logic [2:0]             rsp_id,
    output logic [3:0]             rsp_pix
);
    import sprite_pkg::*;

    localparam logic [ADDR_W-1:0] FISH_LIM  = ADDR_W'(FISH_DEP);
    localparam logic [ADDR_W-1:0] SHARK_LIM = ADDR_W'(SHARK_DEP);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   next_ptr;
    logic              found;
    logic [N_REQ-1:0]  arb_gnt;
    logic [ADDR_W-1:0] win_off;
    logic              win_shark;
    logic              win_right;
    logic              win_oob;
    fetch_stage_t      stage1;
    fetch_stage_t      stage2;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req    (req),
        .rr_ptr (rr_ptr),
        .gnt    (arb_gnt),
        .winner (winner),
        .found  (found)
    );

    assign gnt      = Reset_n ? arb_gnt : '0;
    assign next_ptr = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

    // Pick out the winning requester's offset and sprite attributes and range-check the offset
    always_comb begin
        win_off   = '0;
        win_shark = 1'b0;
        win_right = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_off   = req_off[19*i +: 19];
                win_shark = req_shark[i];
                win_right = req_right[i];
            end
        end
        win_oob = win_shark ? (win_off >= SHARK_LIM) : (win_off >= FISH_LIM);
    end

    // Grant bookkeeping, shared address register and the two response pipeline stages
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rr_ptr   <= '0;
            rom_addr <= '0;
            stage1   <= '0;
            stage2   <= '0;
        end else begin
            stage1.valid <= found;
            stage1.id    <= winner;
            stage1.sel   <= make_sel(win_shark, win_right);
            stage1.oob   <= win_oob;
            stage2       <= stage1;
            if (found && !win_oob) begin
                rom_addr <= win_off;
            end
`ifdef PLAYER_PRIORITY_EN
            if (found && (winner != '0)) begin
                rr_ptr <= next_ptr;
            end
`else
            if (found) begin
                rr_ptr <= next_ptr;
            end
`endif
        end
    end

    // ROM data is valid the cycle stage2 is loaded, so the response mux is combinational off stage2
    always_comb begin
        rsp_valid = stage2.valid;
        rsp_id    = '0;
        rsp_pix   = '0;
        if (stage2.valid) begin
            rsp_id = stage2.id;
            if (stage2.oob) begin
                rsp_pix = TRANSP;
            end else begin
                case (stage2.sel)
                    FISH_L:  rsp_pix = fish_l_d;
                    FISH_R:  rsp_pix = fish_r_d;
                    SHARK_L: rsp_pix = shark_l_d;
                    default: rsp_pix = shark_r_d;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Directed, table-driven bench for sprite_fetch_arbiter. Each table row is one
// clock cycle: inputs applied just after the rising edge, outputs compared on
// the falling edge. The four ROMs are modelled as registered lookups of a
// simple address hash so every ROM returns a distinguishable value.
module tb_sprite_fetch_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  req;
    logic [3:0]  req_shark;
    logic [3:0]  req_right;
    logic [75:0] req_off;
    logic [3:0]  gnt;
    logic [18:0] rom_addr;
    logic [3:0]  fish_l_d;
    logic [3:0]  fish_r_d;
    logic [3:0]  shark_l_d;
    logic [3:0]  shark_r_d;
    logic        rsp_valid;
    logic [2:0]  rsp_id;
    logic [3:0]  rsp_pix;

    int tests_run  = 0;
    int fail_count = 0;

    typedef struct {
        logic        rstn;
        logic [3:0]  req;
        logic [3:0]  shark;
        logic [3:0]  right;
        logic [75:0] offs;
        logic [3:0]  gnt;
        int          addr;
        int          rsp;
        logic [2:0]  id;
        logic [3:0]  pix;
    } row_t;

    row_t tbl[$];

    sprite_fetch_arbiter #(
        .N_REQ (4)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
        .req_shark (req_shark),
        .req_right (req_right),
        .req_off   (req_off),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .fish_l_d  (fish_l_d),
        .fish_r_d  (fish_r_d),
        .shark_l_d (shark_l_d),
        .shark_r_d (shark_r_d),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_pix   (rsp_pix)
    );

    // Free-running 10-unit clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ROM contents: nibble hash of the address plus a per-ROM constant
    function automatic logic [3:0] romVal(input logic [3:0] k, input logic [18:0] a);
        return (a[3:0] ^ a[7:4] ^ a[11:8]) + k;
    endfunction

    // Registered ROMs, one cycle of read latency like the real instances
    always_ff @(posedge Clk) begin
        fish_l_d  <= romVal(4'd0,  rom_addr);
        fish_r_d  <= romVal(4'd3,  rom_addr);
        shark_l_d <= romVal(4'd7,  rom_addr);
        shark_r_d <= romVal(4'd11, rom_addr);
    end

    function automatic logic [75:0] packOffs(input int o0, input int o1, input int o2, input int o3);
        return {19'(o3), 19'(o2), 19'(o1), 19'(o0)};
    endfunction

    task automatic addRow(input logic rstn, input logic [3:0] r, input logic [3:0] sh,
                          input logic [3:0] rt, input logic [75:0] offs, input logic [3:0] g,
                          input int addr, input int rsp, input logic [2:0] id, input logic [3:0] pix);
        row_t row;
        row.rstn  = rstn;
        row.req   = r;
        row.shark = sh;
        row.right = rt;
        row.offs  = offs;
        row.gnt   = g;
        row.addr  = addr;
        row.rsp   = rsp;
        row.id    = id;
        row.pix   = pix;
        tbl.push_back(row);
    endtask

    task automatic applyStimulus(input row_t row);
        Reset_n   = row.rstn;
        req       = row.req;
        req_shark = row.shark;
        req_right = row.right;
        req_off   = row.offs;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [75:0] z;
        logic [75:0] r1;
        logic [75:0] r2;
        z  = '0;
        Reset_n   = 1'b0;
        req       = '0;
        req_shark = '0;
        req_right = '0;
        req_off   = '0;

`ifdef PLAYER_PRIORITY_EN
        addRow(0, 4'hF, 0, 0, z, 4'b0000, -1, -1, 0, 0);
        addRow(0, 4'h0, 0, 0, z, 4'b0000,  0,  0, 0, 0);
        addRow(1, 4'hF, 0, 0, z, 4'b0001, -1, -1, 0, 0);
        addRow(1, 4'hF, 0, 0, z, 4'b0001, -1, -1, 0, 0);
        addRow(1, 4'hF, 0, 0, z, 4'b0001, -1, -1, 0, 0);
        addRow(1, 4'hF, 0, 0, z, 4'b0001, -1, -1, 0, 0);
        addRow(1, 4'hE, 0, 0, z, 4'b0010, -1, -1, 0, 0);
        addRow(1, 4'hE, 0, 0, z, 4'b0100, -1, -1, 0, 0);
        addRow(1, 4'hE, 0, 0, z, 4'b1000, -1, -1, 0, 0);
        addRow(1, 4'hF, 0, 0, z, 4'b0001, -1, -1, 0, 0);
        addRow(1, 4'hE, 0, 0, z, 4'b0010, -1, -1, 0, 0);
`else
        // reset: gnt forced low even with requests pending
        addRow(0, 4'hF, 0, 0, z, 4'b0000, -1, -1, 0, 0);
        addRow(0, 4'h0, 0, 0, z, 4'b0000,  0,  0, 0, 0);
        // single shark-right request, offset 100
        addRow(1, 4'b0010, 4'b0010, 4'b0010, packOffs(0, 100, 0, 0), 4'b0010, 0, 0, 0, 0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 100, 0, 0, 0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 100, 1, 1, romVal(4'd11, 19'd100));
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 100, 0, 0, 0);
        // fish offset 1024 is out of range; shark 49151 is the last valid entry
        addRow(1, 4'b0001, 4'b0000, 4'b0000, packOffs(1024, 0, 0, 0), 4'b0001, 100, 0, 0, 0);
        addRow(1, 4'b1000, 4'b1000, 4'b0000, packOffs(0, 0, 0, 49151), 4'b1000, 100, 0, 0, 0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 49151, 1, 0, 4'h0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 49151, 1, 3, romVal(4'd7, 19'd49151));
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 49151, 0, 0, 0);
        // reset, then all four requesting for eight cycles
        addRow(0, 4'h0, 0, 0, z, 4'b0000, -1, 0, 0, 0);
        r1 = packOffs(1000, 5, 49152, 200);
        r2 = packOffs(1023, 1024, 49151, 0);
        addRow(1, 4'hF, 4'b1100, 4'b1010, r1, 4'b0001, 0, 0, 0, 0);
        addRow(1, 4'hF, 4'b1100, 4'b1010, r1, 4'b0010, 1000, 0, 0, 0);
        addRow(1, 4'hF, 4'b1100, 4'b1010, r1, 4'b0100, 5, 1, 0, romVal(4'd0, 19'd1000));
        addRow(1, 4'hF, 4'b1100, 4'b1010, r1, 4'b1000, 5, 1, 1, romVal(4'd3, 19'd5));
        addRow(1, 4'hF, 4'b1100, 4'b1010, r2, 4'b0001, 200, 1, 2, 4'h0);
        addRow(1, 4'hF, 4'b1100, 4'b1010, r2, 4'b0010, 1023, 1, 3, romVal(4'd11, 19'd200));
        addRow(1, 4'hF, 4'b1100, 4'b1010, r2, 4'b0100, 1023, 1, 0, romVal(4'd0, 19'd1023));
        addRow(1, 4'hF, 4'b1100, 4'b1010, r2, 4'b1000, 49151, 1, 1, 4'h0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 0, 1, 2, romVal(4'd7, 19'd49151));
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 0, 1, 3, romVal(4'd11, 19'd0));
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 0, 0, 0, 0);
        // reset one cycle after a grant drops the in-flight fetch and rewinds the pointer
        addRow(1, 4'b0001, 0, 0, packOffs(300, 0, 0, 0), 4'b0001, 0, 0, 0, 0);
        addRow(0, 4'h0, 0, 0, z, 4'b0000, 300, 0, 0, 0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 0, 0, 0, 0);
        addRow(1, 4'hF, 0, 0, packOffs(18, 0, 0, 0), 4'b0001, 0, 0, 0, 0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 18, 0, 0, 0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 18, 1, 0, romVal(4'd0, 19'd18));
        // req[2] pulses for one cycle while req[1] wins
        addRow(1, 4'b0110, 4'b0000, 4'b0010, packOffs(0, 7, 9, 0), 4'b0010, 18, 0, 0, 0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 7, 0, 0, 0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 7, 1, 1, romVal(4'd3, 19'd7));
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 7, 0, 0, 0);
        addRow(1, 4'h0, 0, 0, z, 4'b0000, 7, 0, 0, 0);
`endif

        foreach (tbl[i]) begin
            @(posedge Clk);
            #1;
            applyStimulus(tbl[i]);
            @(negedge Clk);
            checkOutput($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            if (tbl[i].addr >= 0) begin
                checkOutput($sformatf("row%0d rom_addr", i), 32'(rom_addr), 32'(tbl[i].addr));
            end
            if (tbl[i].rsp >= 0) begin
                checkOutput($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].rsp));
                if (tbl[i].rsp == 1) begin
                    checkOutput($sformatf("row%0d rsp_id", i), 32'(rsp_id), 32'(tbl[i].id));
                    checkOutput($sformatf("row%0d rsp_pix", i), 32'(rsp_pix), 32'(tbl[i].pix));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
